// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the Op encodings, the FSM state type, the divide defaults and the
// absolute-value helper that the top level uses to feed the unsigned divider.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam int unsigned DIV_ITERS_DEF = 32;

  // LO result of a divide by zero.
  localparam logic [31:0] DIVZ_LO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_ITER,
    DIV_FIX
  } state_t;

  // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// One-bit-per-cycle restoring divider on unsigned 32-bit operands.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture dividend/divisor and clear the partial remainder
//   step              produce one quotient bit (MSB first)
//   dividend, divisor operands, sampled on load
//   quotient          quotient bits shifted in so far (complete after 32 steps)
//   remainder         partial remainder (final after 32 steps)
// A zero divisor yields garbage here; the caller overrides that case.
module div_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dq_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] rem_q;
  logic [31:0] dvs_q;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;

  assign shifted = {rem_q, dq_q[31]};
  assign fits    = shifted >= {1'b0, dvs_q};
  // When fits is set the difference is below the divisor, so 32 bits suffice.
  assign diff    = shifted[31:0] - dvs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q  <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      dq_q  <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? diff : shifted[31:0];
      dq_q  <= {dq_q[30:0], fits};
    end
  end

  assign quotient  = dq_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage.
// Owns the architectural HI/LO pair and runs MULT/MULTU/MADD/MSUB over
// MUL_LAT cycles and DIV/DIVU over DIV_ITERS+1 cycles; MTHI/MTLO write at once.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   Start, Op    issue strobe and operation (hilo_pkg OP_* encodings)
//   A, B         rs / rt operands
//   HiLoRead     MFHI/MFLO present in execute
//   Hi, Lo       architectural registers
//   Busy         operation in flight
//   Done         registered one-cycle pulse, first cycle with the new Hi/Lo
//   Stall        HiLoRead & Busy
//   IssueErr     registered one-cycle pulse after a Start that arrived while Busy
// Build option: define HILO_ACCUM_EN to implement MADD/MSUB; otherwise they
// complete as no-ops and the accumulator adder is not built.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoRead,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        Stall,
  output logic        IssueErr
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, err_q, err_d;

  logic        div_load, div_step;
  logic        div_signed;
  logic [31:0] quo, rem;
  logic        q_neg, r_neg;
  logic [31:0] q_fix, r_fix;

  logic [63:0] prod_s, prod_u, mul_res;

  assign div_signed = (Op == OP_DIV);

  div_iter_core u_div (
    .clk       (Clk),
    .rst       (Reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_signed ? abs32(A) : A),
    .divisor   (div_signed ? abs32(B) : B),
    .quotient  (quo),
    .remainder (rem)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_neg = (op_q == OP_DIV) & (a_q[31] ^ b_q[31]);
  assign r_neg = (op_q == OP_DIV) & a_q[31];
  assign q_fix = q_neg ? (~quo + 32'd1) : quo;
  assign r_fix = r_neg ? (~rem + 32'd1) : rem;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

`ifdef HILO_ACCUM_EN
  logic [63:0] hilo;
  assign hilo = {hi_q, lo_q};
`endif

  always_comb begin
    mul_res = prod_s;
    case (op_q)
      OP_MULTU: mul_res = prod_u;
`ifdef HILO_ACCUM_EN
      OP_MADD:  mul_res = hilo + prod_s;
      OP_MSUB:  mul_res = hilo - prod_s;
`endif
      default:  mul_res = prod_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d = Op;
          a_d  = A;
          b_d  = B;
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              cnt_d    = 6'(DIV_ITERS - 1);
              state_d  = DIV_ITER;
            end
`ifndef HILO_ACCUM_EN
            OP_MADD, OP_MSUB: done_d = 1'b1;
`endif
            default: begin
              cnt_d   = 6'(MUL_LAT - 1);
              state_d = MUL_WAIT;
            end
          endcase
        end
      end
      MUL_WAIT: begin
        if (cnt_q == 6'd0) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV_ITER: begin
        div_step = 1'b1;
        if (cnt_q == 6'd0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV_FIX: begin
        if (b_q == 32'd0) begin
          lo_d = DIVZ_LO;
          hi_d = a_q;
        end else begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (Start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign IssueErr = err_q;
  assign Stall    = HiLoRead & Busy;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: each issued operation pushes its
// hand-computed Hi/Lo into a queue, and a monitor compares on every Done.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, HiLoRead;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, Stall, IssueErr;

  int tests = 0;
  int fails = 0;
  int pushes = 0;
  int dones = 0;
  int next_id = 0;

  logic [31:0] exp_hi[$];
  logic [31:0] exp_lo[$];
  int          exp_id[$];

  hilo_muldiv_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .HiLoRead (HiLoRead),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall),
    .IssueErr (IssueErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo);
    exp_hi.push_back(hi);
    exp_lo.push_back(lo);
    exp_id.push_back(next_id);
    next_id++;
    pushes++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Issues one operation and returns how many sampled cycles Busy stayed high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, output int busy_cycles);
    expect_result(hi, lo);
    issue(op, a, b);
    busy_cycles = 0;
    while (Busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge Clk);
    end
  endtask

  // Monitor: every Done must match the oldest pending result.
  always @(negedge Clk) begin : monitor
    int          id;
    logic [31:0] eh, el;
    if (!Reset && Done) begin
      dones++;
      if (exp_hi.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: Done=1 with nothing pending, Hi=%h Lo=%h", Hi, Lo);
      end else begin
        id = exp_id.pop_front();
        eh = exp_hi.pop_front();
        el = exp_lo.pop_front();
        check($sformatf("result%0d_hi", id), Hi, eh);
        check($sformatf("result%0d_lo", id), Lo, el);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bc;
    int cyc;
    int stall_bad;
    int hold_bad;

    Reset    = 1'b1;
    Start    = 1'b0;
    Op       = OP_MULT;
    A        = '0;
    B        = '0;
    HiLoRead = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_issueerr", 32'(IssueErr), 32'd0);
    Reset = 1'b0;

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, bc);
    check("mult_busy_cycles", bc, 32'd2);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, bc);
    check("multu_busy_cycles", bc, 32'd2);

    // DIV -7/2 with an MFHI waiting, plus a rejected second Start at cycle 5.
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    HiLoRead  = 1'b1;
    cyc       = 0;
    stall_bad = 0;
    hold_bad  = 0;
    while (Busy && cyc < 100) begin
      #1;
      if (Stall !== 1'b1) stall_bad++;
      if (Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001) hold_bad++;
      if (cyc == 5) begin
        Start = 1'b1;
        Op    = OP_MULT;
        A     = 32'd9;
        B     = 32'd9;
      end
      if (cyc == 6) begin
        Start = 1'b0;
        check("issueerr_pulse", 32'(IssueErr), 32'd1);
      end
      if (cyc == 7) check("issueerr_clear", 32'(IssueErr), 32'd0);
      cyc++;
      @(negedge Clk);
    end
    check("div_busy_cycles", cyc, 32'd33);
    check("div_stall_missing", stall_bad, 32'd0);
    check("div_hilo_held", hold_bad, 32'd0);
    #1;
    check("stall_after_done", 32'(Stall), 32'd0);
    HiLoRead = 1'b0;

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, bc);
    run_op(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, bc);
    check("divz_busy_cycles", bc, 32'd33);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, bc);
    run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, bc);

    // Start and HiLoRead together in IDLE: no stall, read sees the old Hi.
    expect_result(32'd0, 32'hFFFFFFFF);
    @(negedge Clk);
    Start    = 1'b1;
    Op       = OP_MTHI;
    A        = 32'd0;
    HiLoRead = 1'b1;
    #1;
    check("same_cycle_stall", 32'(Stall), 32'd0);
    check("same_cycle_old_hi", Hi, 32'hFFFFFFFB);
    @(negedge Clk);
    Start    = 1'b0;
    HiLoRead = 1'b0;

    run_op(OP_MTLO, 32'd5, 32'd0, 32'd0, 32'd5, bc);
    check("mtlo_busy_cycles", bc, 32'd0);
`ifdef HILO_ACCUM_EN
    run_op(OP_MADD, 32'd2, 32'd3, 32'd0, 32'd11, bc);
    check("madd_busy_cycles", bc, 32'd2);
    run_op(OP_MSUB, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFB, bc);
    check("msub_busy_cycles", bc, 32'd2);
`else
    run_op(OP_MADD, 32'd2, 32'd3, 32'd0, 32'd5, bc);
    check("madd_noop_busy_cycles", bc, 32'd0);
    run_op(OP_MSUB, 32'd4, 32'd4, 32'd0, 32'd5, bc);
    check("msub_noop_busy_cycles", bc, 32'd0);
`endif

    // Reset in the middle of a DIV discards it.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge Clk);
    check("div_midway_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("midreset_hi", Hi, 32'd0);
    check("midreset_lo", Lo, 32'd0);
    check("midreset_busy", 32'(Busy), 32'd0);
    repeat (2) @(negedge Clk);
    check("midreset_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("postreset_done", 32'(Done), 32'd0);
    check("postreset_busy", 32'(Busy), 32'd0);
    run_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, bc);
    check("postreset_mult_busy", bc, 32'd2);

    repeat (3) @(negedge Clk);
    check("pending_results", exp_hi.size(), 32'd0);
    check("done_count", dones, pushes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
